// File: rtl/alu_unit.sv
// Execution-stage ALU: single-cycle logic/arithmetic ops plus a W-step shift-add multiplier.
// Results and {Z,C,N,V} flags are registered and update only on the edge that raises done.
module alu_unit #(
    parameter int DATA_BUS_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [3:0]                op,
    input  logic [DATA_BUS_WIDTH-1:0] operand_a,
    input  logic [DATA_BUS_WIDTH-1:0] operand_b,
    output logic [DATA_BUS_WIDTH-1:0] result,
    output logic [DATA_BUS_WIDTH-1:0] result_hi,
    output logic [3:0]                flags,
    output logic                      busy,
    output logic                      done
);

    // state   | meaning
    // S_IDLE  | waiting for start; single-cycle ops complete here
    // S_MUL   | shift-add multiply in progress, one step per cycle

    localparam int W  = DATA_BUS_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;
    localparam logic [3:0] OP_DEC = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12;
    localparam logic [3:0] OP_MUL = 4'd13;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    state_e          state_q;
    logic [W-1:0]    result_q;
    logic [W-1:0]    result_hi_q;
    logic [3:0]      flags_q;
    logic            busy_q;
    logic            done_q;
    logic [2*W-1:0]  mcand_q;
    logic [W-1:0]    mplier_q;
    logic [2*W-1:0]  acc_q;
    logic [CW-1:0]   cnt_q;

    logic [2*W-1:0]  acc_d;
    logic [W:0]      arith;
    logic [W-1:0]    rhs;
    logic            cin;
    logic [W-1:0]    res_d;
    logic            c_d;
    logic            v_d;
    logic            wr_res;
    logic            wr_flg;

    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        arith  = '0;
        rhs    = operand_b;
        cin    = 1'b0;
        res_d  = '0;
        c_d    = 1'b0;
        v_d    = 1'b0;
        wr_res = 1'b1;
        wr_flg = 1'b1;
        case (op)
            OP_ADD, OP_ADC, OP_INC: begin
                if (op == OP_INC) rhs = {{(W-1){1'b0}}, 1'b1};
                if (op == OP_ADC) cin = flags_q[2];
                arith = {1'b0, operand_a} + {1'b0, rhs} + {{W{1'b0}}, cin};
                res_d = arith[W-1:0];
                c_d   = arith[W];
                v_d   = (operand_a[W-1] == rhs[W-1]) && (arith[W-1] != operand_a[W-1]);
            end
            OP_SUB, OP_SBC, OP_DEC, OP_CMP: begin
                if (op == OP_DEC) rhs = {{(W-1){1'b0}}, 1'b1};
                if (op == OP_SBC) cin = flags_q[2];
                // bit W of the (W+1)-bit difference is the unsigned borrow
                arith  = {1'b0, operand_a} - {1'b0, rhs} - {{W{1'b0}}, cin};
                res_d  = arith[W-1:0];
                c_d    = arith[W];
                v_d    = (operand_a[W-1] != rhs[W-1]) && (arith[W-1] != operand_a[W-1]);
                wr_res = (op != OP_CMP);
            end
            OP_AND: res_d = operand_a & operand_b;
            OP_OR:  res_d = operand_a | operand_b;
            OP_XOR: res_d = operand_a ^ operand_b;
            OP_NOT: res_d = ~operand_a;
            OP_SHL: begin
                res_d = {operand_a[W-2:0], 1'b0};
                c_d   = operand_a[W-1];
            end
            OP_SHR: begin
                res_d = {1'b0, operand_a[W-1:1]};
                c_d   = operand_a[0];
            end
            default: begin
                wr_res = 1'b0;
                wr_flg = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            mcand_q  <= {{W{1'b0}}, operand_a};
                            mplier_q <= operand_b;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= S_MUL;
                        end else begin
                            done_q <= 1'b1;
                            if (wr_res) begin
                                result_q    <= res_d;
                                result_hi_q <= '0;
                            end
                            if (wr_flg) flags_q <= {res_d == '0, c_d, res_d[W-1], v_d};
                        end
                    end
                end
                S_MUL: begin
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    acc_q    <= acc_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        result_q    <= acc_d[W-1:0];
                        result_hi_q <= acc_d[2*W-1:W];
                        flags_q     <= {acc_d[W-1:0] == '0, acc_d[2*W-1:W] != '0, acc_d[W-1], 1'b0};
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit (W=8) with hand-computed expectations.
// Flags are compared as {Z,C,N,V}.
module tb_alu_unit;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] op;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic [3:0] flags;
    logic       busy;
    logic       done;

    int chk_cnt = 0;
    int err_cnt = 0;

    alu_unit #(.DATA_BUS_WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse; on return we are 1ns after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        @(negedge clock);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic single(input string tag, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_res, input logic [7:0] exp_hi, input logic [3:0] exp_flg);
        issue(o, a, b);
        check({tag, "_done"}, done, 1);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_hi"}, result_hi, exp_hi);
        check({tag, "_flags"}, flags, exp_flg);
    endtask

    initial begin
        int busy_cycles;
        int done_k;
        int done_seen;

        reset     = 1'b0;
        start     = 1'b0;
        op        = 4'd0;
        operand_a = 8'h00;
        operand_b = 8'h00;
        #12;
        check("rst_res", result, 0);
        check("rst_hi", result_hi, 0);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clock);
        reset = 1'b1;

        single("add_ff_01", 4'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1100);
        @(posedge clock); #1;
        check("add_done_drop", done, 0);
        single("adc_carry", 4'd2, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0000);
        single("sub_80_01", 4'd1, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0001);
        single("cmp_eq", 4'd12, 8'h42, 8'h42, 8'h7F, 8'h00, 4'b1000);
        single("sub_01_02", 4'd1, 8'h01, 8'h02, 8'hFF, 8'h00, 4'b0110);
        single("sbc_borrow", 4'd3, 8'h05, 8'h02, 8'h02, 8'h00, 4'b0000);
        single("dec_00", 4'd11, 8'h00, 8'h00, 8'hFF, 8'h00, 4'b0110);
        single("inc_7f", 4'd10, 8'h7F, 8'h00, 8'h80, 8'h00, 4'b0011);
        single("shl_81", 4'd8, 8'h81, 8'h00, 8'h02, 8'h00, 4'b0100);
        single("not_ff", 4'd7, 8'hFF, 8'h00, 8'h00, 8'h00, 4'b1000);
        single("xor_a5", 4'd6, 8'hA5, 8'h0F, 8'hAA, 8'h00, 4'b0010);
        single("and_f0", 4'd4, 8'hF3, 8'h3C, 8'h30, 8'h00, 4'b0000);
        single("or_80", 4'd5, 8'h80, 8'h01, 8'h81, 8'h00, 4'b0010);

        // MUL 0xFF*0xFF with an ADD start pulse during cycle 3 that must be dropped
        issue(4'd13, 8'hFF, 8'hFF);
        busy_cycles = 0;
        done_k      = 0;
        for (int k = 1; k <= 20; k++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_k = k;
                break;
            end
            if (k == 2) operand_a = 8'h00;
            if (k == 3) begin
                start     = 1'b1;
                op        = 4'd0;
                operand_a = 8'h01;
                operand_b = 8'h01;
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
        end
        check("mul_done_k", done_k, 9);
        check("mul_busy_cycles", busy_cycles, 8);
        check("mul_busy_at_done", busy, 0);
        check("mul_res", result, 8'h01);
        check("mul_hi", result_hi, 8'hFE);
        check("mul_flags", flags, 4'b0100);
        done_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            if (done) done_seen++;
        end
        check("mul_no_extra_done", done_seen, 0);
        check("mul_res_hold", result, 8'h01);

        single("cmp_keeps_hi", 4'd12, 8'h42, 8'h42, 8'h01, 8'hFE, 4'b1000);
        single("shr_81", 4'd9, 8'h81, 8'h00, 8'h40, 8'h00, 4'b0100);
        single("add_88_88", 4'd0, 8'h88, 8'h88, 8'h10, 8'h00, 4'b0101);
        single("nop_15", 4'd15, 8'hFF, 8'hFF, 8'h10, 8'h00, 4'b0101);

        // Reset mid-MUL after four steps
        issue(4'd13, 8'h03, 8'h05);
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_res", result, 0);
        check("abort_hi", result_hi, 0);
        check("abort_flags", flags, 0);
        check("abort_done", done, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock); #1;
            if (done || busy) done_seen++;
        end
        check("abort_quiet", done_seen, 0);
        single("post_abort_add", 4'd0, 8'h02, 8'h03, 8'h05, 8'h00, 4'b0000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
